// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: walks pc through instruction memory, latches ir,
// and issues single-cycle register-file / data-memory write strobes from WB / MEM.
module instr_sequencer #(
    parameter int PC_W     = 10,
    parameter int IW       = 9,
    parameter int PROG_LEN = 1023,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IW-1:0]    instr,
    input  logic             branch,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    input  logic             zero,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc,
    output logic [IW-1:0]    ir,
    output logic             reg_we,
    output logic             mem_we,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // One extra bit so a wrap past the top of the address space still reads as end-of-program.
    localparam logic [PC_W:0] END_PC = (PC_W + 1)'(PROG_LEN);

    state_t           state_r, state_s;
    logic [PC_W-1:0]  pc_r, pc_s;
    logic [IW-1:0]    ir_r, ir_s;
    logic [CNT_W-1:0] retired_r, retired_s;

    logic [PC_W:0]    pc_inc_s;
    logic [PC_W:0]    br_next_s;
    logic [CNT_W-1:0] retire_s;
    state_t           adv_state_s;
    state_t           br_state_s;

    assign pc_inc_s    = {1'b0, pc_r} + {{PC_W{1'b0}}, 1'b1};
    assign br_next_s   = zero ? {1'b0, target} : pc_inc_s;
    assign retire_s    = (&retired_r) ? retired_r : retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign adv_state_s = (pc_inc_s >= END_PC) ? S_DONE : S_FETCH;
    assign br_state_s  = (br_next_s >= END_PC) ? S_DONE : S_FETCH;

    // Next-state and datapath register update selection.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ir_s      = ir_r;
        retired_s = retired_r;
        case (state_r)
            S_IDLE: begin
                pc_s = '0;
                if (start) begin
                    retired_s = '0;
                    state_s   = S_FETCH;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_FETCH: begin
                ir_s    = instr;
                state_s = S_EXEC;
            end
            S_EXEC: begin
                if (branch) begin
                    pc_s      = br_next_s[PC_W-1:0];
                    retired_s = retire_s;
                    state_s   = br_state_s;
                end else if (mem_write || mem_to_reg) begin
                    state_s   = S_MEM;
                end else begin
                    state_s   = S_WB;
                end
            end
            S_MEM: begin
                if (mem_write) begin
                    pc_s      = pc_inc_s[PC_W-1:0];
                    retired_s = retire_s;
                    state_s   = adv_state_s;
                end else begin
                    state_s   = S_WB;
                end
            end
            S_WB: begin
                pc_s      = pc_inc_s[PC_W-1:0];
                retired_s = retire_s;
                state_s   = adv_state_s;
            end
            S_DONE: begin
                if (start) begin
                    pc_s      = '0;
                    retired_s = '0;
                    state_s   = S_FETCH;
                end else begin
                    state_s   = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            pc_r      <= '0;
            ir_r      <= '0;
            retired_r <= '0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_r      <= ir_s;
            retired_r <= retired_s;
        end
    end

    // Strobes are Moore-decoded from state and qualified by the decoder for the held ir.
    assign reg_we  = (state_r == S_WB) && reg_write;
    assign mem_we  = (state_r == S_MEM) && mem_write;
    assign busy    = (state_r == S_FETCH) || (state_r == S_EXEC) ||
                     (state_r == S_MEM) || (state_r == S_WB);
    assign done    = (state_r == S_DONE);
    assign pc      = pc_r;
    assign ir      = ir_r;
    assign retired = retired_r;

endmodule
